// File: rtl/pc_return_stack.sv
// Program counter with a hardware return-address stack. Executes the branch
// controller's next-address select and call/return push/pop each enabled cycle.
module pc_return_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 addrSrc,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          branchAddr,
    input  logic [ADDR_W-1:0]          jumpAddr,
    output logic [ADDR_W-1:0]          pc,
    output logic [ADDR_W-1:0]          tos,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SP_W  = PTR_W + 1;

    logic [ADDR_W-1:0] pc_r;
    logic [SP_W-1:0]   sp_r;
    logic              overflow_r;
    logic              underflow_r;
    logic [ADDR_W-1:0] stack_r [DEPTH];

    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] tos_s;
    logic [PTR_W-1:0]  top_idx_s;
    logic              empty_s;
    logic              full_s;

    logic [ADDR_W-1:0] pc_nxt_s;
    logic [SP_W-1:0]   sp_nxt_s;
    logic              overflow_nxt_s;
    logic              underflow_nxt_s;
    logic              wr_en_s;
    logic [PTR_W-1:0]  wr_idx_s;

    // Status derived from registered state only.
    always_comb begin
        pc_inc_s  = pc_r + ADDR_W'(1);
        empty_s   = (sp_r == SP_W'(0));
        full_s    = (sp_r == SP_W'(DEPTH));
        top_idx_s = PTR_W'(sp_r - SP_W'(1));
        if (empty_s) begin
            tos_s = {ADDR_W{1'b0}};
        end else begin
            tos_s = stack_r[top_idx_s];
        end
    end

    // Next PC selection and stack operation decode.
    always_comb begin
        pc_nxt_s        = pc_inc_s;
        sp_nxt_s        = sp_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        wr_en_s         = 1'b0;
        wr_idx_s        = sp_r[PTR_W-1:0];

        case (addrSrc)
            2'b00: pc_nxt_s = pc_inc_s;
            2'b01: begin
                if (empty_s) begin
                    pc_nxt_s        = pc_inc_s;
                    underflow_nxt_s = 1'b1;
                end else begin
                    pc_nxt_s = tos_s;
                end
            end
            2'b10: pc_nxt_s = branchAddr;
            2'b11: pc_nxt_s = jumpAddr;
            default: pc_nxt_s = pc_inc_s;
        endcase

        // Simultaneous push/pop replaces the top entry; on an empty stack the
        // pop half is the error and the push still lands in entry 0.
        if (push && pop) begin
            wr_en_s = 1'b1;
            if (empty_s) begin
                wr_idx_s        = {PTR_W{1'b0}};
                sp_nxt_s        = SP_W'(1);
                underflow_nxt_s = 1'b1;
            end else begin
                wr_idx_s = top_idx_s;
                sp_nxt_s = sp_r;
            end
        end else if (push) begin
            if (full_s) begin
                overflow_nxt_s = 1'b1;
            end else begin
                wr_en_s  = 1'b1;
                sp_nxt_s = sp_r + SP_W'(1);
            end
        end else if (pop) begin
            if (empty_s) begin
                underflow_nxt_s = 1'b1;
            end else begin
                sp_nxt_s = sp_r - SP_W'(1);
            end
        end else begin
            sp_nxt_s = sp_r;
        end
    end

    // PC, stack pointer and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r        <= {ADDR_W{1'b0}};
            sp_r        <= {SP_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (en) begin
            pc_r        <= pc_nxt_s;
            sp_r        <= sp_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Return-address storage; contents need no reset since sp gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && en && wr_en_s) begin
            stack_r[wr_idx_s] <= pc_inc_s;
        end
    end

    assign pc        = pc_r;
    assign tos       = tos_s;
    assign sp        = sp_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench for pc_return_stack: directed scenarios plus random traffic
// checked against a queue-based return-stack model.
module tb_pc_return_stack;

    localparam int AW = 12;
    localparam int D  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    addr_src = 2'b00;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] branch_addr = '0;
    logic [AW-1:0] jump_addr = '0;
    logic [AW-1:0] pc;
    logic [AW-1:0] tos;
    logic [SW-1:0] sp;
    logic          full, empty, overflow, underflow;

    pc_return_stack #(.ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .addrSrc(addr_src),
        .push(push), .pop(pop), .branchAddr(branch_addr), .jumpAddr(jump_addr),
        .pc(pc), .tos(tos), .sp(sp), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] tos;
        logic [SW-1:0] sp;
        logic          full;
        logic          empty;
        logic          ov;
        logic          un;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the stack is a plain queue, top at the back.
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_stk[$];
    logic          m_ov = 1'b0;
    logic          m_un = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.tos   = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
        e.sp    = SW'(m_stk.size());
        e.full  = (m_stk.size() == D);
        e.empty = (m_stk.size() == 0);
        e.ov    = m_ov;
        e.un    = m_un;
        return e;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic [1:0] a,
                                input logic pu, input logic po,
                                input logic [AW-1:0] ba, input logic [AW-1:0] ja);
        logic [AW-1:0] inc;
        logic [AW-1:0] npc;
        if (!r) begin
            m_pc = '0;
            m_stk.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else if (e) begin
            inc = m_pc + 12'd1;
            npc = inc;
            if (a == 2'b01) begin
                if (m_stk.size() == 0) m_un = 1'b1;
                else npc = m_stk[m_stk.size()-1];
            end else if (a == 2'b10) begin
                npc = ba;
            end else if (a == 2'b11) begin
                npc = ja;
            end
            if (pu && po) begin
                if (m_stk.size() > 0) begin
                    m_stk[m_stk.size()-1] = inc;
                end else begin
                    m_stk.push_back(inc);
                    m_un = 1'b1;
                end
            end else if (pu) begin
                if (m_stk.size() == D) m_ov = 1'b1;
                else m_stk.push_back(inc);
            end else if (po) begin
                if (m_stk.size() == 0) m_un = 1'b1;
                else void'(m_stk.pop_back());
            end
            m_pc = npc;
        end
    endtask

    // Drive inputs, let one edge happen, record the expected state, return at negedge.
    task automatic step(input logic r, input logic e, input logic [1:0] a,
                        input logic pu, input logic po,
                        input logic [AW-1:0] ba, input logic [AW-1:0] ja);
        rst_n = r; en = e; addr_src = a; push = pu; pop = po;
        branch_addr = ba; jump_addr = ja;
        @(posedge clk);
        model_update(r, e, a, pu, po, ba, ja);
        exp_q.push_back(model_snapshot());
        @(negedge clk);
    endtask

    task automatic go(input logic [1:0] a, input logic pu, input logic po,
                      input logic [AW-1:0] target);
        step(1'b1, 1'b1, a, pu, po, target, target);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 12'h000, 12'h555);
    endtask

    // Monitor: each edge the DUT presents a new state; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc", 32'(pc), 32'(e.pc));
                cmp("tos", 32'(tos), 32'(e.tos));
                cmp("sp", 32'(sp), 32'(e.sp));
                cmp("full", 32'(full), 32'(e.full));
                cmp("empty", 32'(empty), 32'(e.empty));
                cmp("overflow", 32'(overflow), 32'(e.ov));
                cmp("underflow", 32'(underflow), 32'(e.un));
            end
        end
    end

    initial begin
        // Reset then sequential fetch.
        do_reset();
        cmp("reset_pc", 32'(pc), 32'h0);
        cmp("reset_empty", 32'(empty), 32'h1);
        for (int i = 0; i < 4; i++) go(2'b00, 1'b0, 1'b0, 12'h000);
        cmp("seq_pc", 32'(pc), 32'h4);

        // Call and return.
        go(2'b10, 1'b0, 1'b0, 12'h010);
        go(2'b11, 1'b1, 1'b0, 12'h200);
        cmp("call_pc", 32'(pc), 32'h200);
        cmp("call_tos", 32'(tos), 32'h011);
        cmp("call_sp", 32'(sp), 32'h1);
        go(2'b00, 1'b0, 1'b0, 12'h000);
        go(2'b00, 1'b0, 1'b0, 12'h000);
        go(2'b01, 1'b0, 1'b1, 12'h000);
        cmp("ret_pc", 32'(pc), 32'h011);
        cmp("ret_sp", 32'(sp), 32'h0);

        // Nested calls to full depth, then overflow.
        go(2'b10, 1'b0, 1'b0, 12'h020);
        for (int i = 0; i < D; i++) go(2'b11, 1'b1, 1'b0, AW'(12'h300 + 16 * i));
        cmp("nest_full", 32'(full), 32'h1);
        cmp("nest_tos", 32'(tos), 32'h361);
        go(2'b11, 1'b1, 1'b0, 12'h3F0);
        cmp("ovf_flag", 32'(overflow), 32'h1);
        cmp("ovf_pc", 32'(pc), 32'h3F0);
        cmp("ovf_sp", 32'(sp), 32'h8);
        for (int i = 0; i < D; i++) go(2'b01, 1'b0, 1'b1, 12'h000);
        cmp("unwind_pc", 32'(pc), 32'h021);
        cmp("unwind_sp", 32'(sp), 32'h0);

        // Return on empty stack.
        go(2'b10, 1'b0, 1'b0, 12'h050);
        go(2'b01, 1'b0, 1'b1, 12'h000);
        cmp("unf_pc", 32'(pc), 32'h051);
        cmp("unf_flag", 32'(underflow), 32'h1);
        for (int i = 0; i < 5; i++) go(2'b00, 1'b0, 1'b0, 12'h000);
        cmp("unf_sticky", 32'(underflow), 32'h1);

        // Enable low, branch, wraparound.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 12'h777, 12'h777);
        cmp("hold_pc", 32'(pc), 32'h056);
        cmp("hold_sp", 32'(sp), 32'h0);
        go(2'b10, 1'b0, 1'b0, 12'h0AB);
        cmp("branch_pc", 32'(pc), 32'h0AB);
        go(2'b10, 1'b0, 1'b0, 12'hFFF);
        go(2'b00, 1'b0, 1'b0, 12'h000);
        cmp("wrap_pc", 32'(pc), 32'h000);

        // Swap: push+pop+return with two entries.
        do_reset();
        go(2'b10, 1'b0, 1'b0, 12'h07F);
        go(2'b11, 1'b1, 1'b0, 12'h03F);
        go(2'b11, 1'b1, 1'b0, 12'h100);
        cmp("pre_swap_tos", 32'(tos), 32'h040);
        go(2'b01, 1'b1, 1'b1, 12'h000);
        cmp("swap_pc", 32'(pc), 32'h040);
        cmp("swap_tos", 32'(tos), 32'h101);
        cmp("swap_sp", 32'(sp), 32'h2);
        go(2'b01, 1'b1, 1'b0, 12'h000);
        do_reset();
        cmp("midrst_sp", 32'(sp), 32'h0);
        cmp("midrst_pc", 32'(pc), 32'h0);
        cmp("midrst_flags", 32'({overflow, underflow}), 32'h0);
        // Push+pop on an empty stack acts as a push and flags underflow.
        go(2'b00, 1'b1, 1'b1, 12'h000);
        cmp("pp_empty_sp", 32'(sp), 32'h1);
        cmp("pp_empty_unf", 32'(underflow), 32'h1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 2) == 0), AW'($urandom), AW'($urandom));
        end

        repeat (2) @(negedge clk);
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_return_stack.md
# pc_return_stack

Program-counter register and hardware return-address stack that executes the next-address decisions produced by the branch controller (`addrSrc`, `push`, `pop`). Each enabled cycle it selects the next PC and performs the call/return stack operation. It sits between the branch controller and the instruction memory address port of the multicycle/pipelined core.

## Interface

Parameters:
- `ADDR_W`, 12, width of PC and all addresses
- `DEPTH`, 8, number of return-address entries (power of two, ≥2)

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is synchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `en`  in  1  advance PC / perform stack op this cycle
- `addrSrc`  in  2  next-PC select: 00 PC+1, 01 return (top of stack), 10 branch target, 11 jump/call target
- `push`  in  1  call: push PC+1
- `pop`  in  1  return: pop top entry
- `branchAddr`  in  ADDR_W  conditional branch target
- `jumpAddr`  in  ADDR_W  jump/call target
- `pc`  out  ADDR_W  current program counter (registered)
- `tos`  out  ADDR_W  top-of-stack entry (entry sp-1); 0 when empty
- `sp`  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
- `full`  out  1  sp == DEPTH
- `empty`  out  1  sp == 0
- `overflow`  out  1  sticky: push attempted while full
- `underflow`  out  1  sticky: pop or addrSrc=01 attempted while empty

## Operation

- Reset (`rst_n`=0 at edge): `pc`=0, `sp`=0, `overflow`=`underflow`=0. Stack contents are don't-care; `tos` reads 0 because the stack is empty, `empty`=1, `full`=0.
- `en`=0: all state holds, and `push`/`pop`/`addrSrc` are ignored.
- `en`=1, next PC:
  - 00 → `pc`+1, modulo 2^ADDR_W, so 0xFFF → 0x000.
  - 01 → `tos`; when empty, `pc`+1 and `underflow` set.
  - 10 → `branchAddr`.
  - 11 → `jumpAddr`.
- `en`=1, stack: `push` and `pop` act independently of `addrSrc`.
  - Push (not full): entry[sp] ← `pc`+1 (old pc), sp++.
  - Push while full: no write, sp unchanged, `overflow` set; PC update still occurs.
  - Pop (not empty): sp--; stack data is unchanged.
  - Pop while empty: sp stays 0, `underflow` set.
  - `push` & `pop` together with sp>0: entry[sp-1] ← `pc`+1, sp unchanged. With addrSrc=01 the PC takes the *old* top value (swap).
  - `push` & `pop` together with sp=0: behaves as push only, and `underflow` set.
- Sticky flags clear only on reset.
- `tos`, `full`, `empty`, `sp` are combinational from registered state; no input-to-output combinational path.

## Timing

- All updates occur on the rising `clk` edge when `en`=1. The new `pc` and `sp` are visible in the cycle after the edge (1-cycle latency).
- Reset takes priority over `en`.
- `tos` after a push equals the pushed value in the next cycle. A call followed by an immediate return in the next enabled cycle returns correctly with no bypass needed.
- Flags assert in the cycle after the offending edge and remain asserted.
- Reset mid-sequence discards all stack entries; the following enabled cycle starts from `pc`=0.

## Test plan

- Reset, then 4 enabled cycles with addrSrc=00 → `pc` 0,1,2,3,4; `empty`=1; flags 0.
- At `pc`=0x010: call (addrSrc=11, push, jumpAddr=0x200), then 2×00, then return (addrSrc=01, pop) → `pc` 0x200, 0x201, 0x202, 0x011; `sp` 1→0; `tos` 0x011 while sp=1.
- Nested calls to depth 8 from `pc`=0x020, 0x300, …, then a 9th call → `full`=1, `overflow`=1, and the PC still jumps. Then 8 returns unwind in LIFO order with `sp` 8→0.
- Return on empty stack at `pc`=0x050 → `pc`=0x051, `underflow`=1, `sp`=0; the flag remains after 5 normal cycles.
- `en`=0 for 3 cycles with push=1, addrSrc=11 → `pc`, `sp` unchanged. Branch with addrSrc=10, branchAddr=0x0AB → `pc`=0x0AB. With `pc`=0xFFF and addrSrc=00 → `pc`=0x000.
- push & pop & addrSrc=01 at `pc`=0x100 with `tos`=0x040, sp=2 → `pc`=0x040, `tos`=0x101, sp=2. Assert `rst_n`=0 mid-stack → `sp`=0, `pc`=0, flags cleared.
